// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: program counter, memory address register and a
// one-hot T-state ring that runs fetch (T1..T3) and execute (T4..Tn) cycles.
module fetch_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int T_STATES   = 6,
  parameter int RESET_ADDR = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_jump,
  input  logic [ADDR_WIDTH-1:0] i_jump_addr,
  input  logic                  i_end,
  input  logic                  i_halt,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [T_STATES-1:0]   o_tstate,
  output logic                  o_ir_load,
  output logic                  o_wrap,
  output logic                  o_halted
);

  typedef enum logic {
    MODE_RUN,
    MODE_HALTED
  } mode_t;

  localparam logic [ADDR_WIDTH-1:0] LP_RESET_ADDR = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_ALL_ONES   = {ADDR_WIDTH{1'b1}};
  localparam logic [T_STATES-1:0]   LP_T1         = {{(T_STATES-1){1'b0}}, 1'b1};

  mode_t                 r_mode;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [T_STATES-1:0]   r_tstate;
  logic                  r_wrap;

  logic                  w_legal;
  logic                  w_in_exec;
  logic [T_STATES-1:0]   w_next_ring;

  // A corrupted ring (zero or multi-hot) is caught here and forced back to T1.
  assign w_legal     = (r_tstate != '0) && ((r_tstate & (r_tstate - 1'b1)) == '0);
  assign w_in_exec   = |r_tstate[T_STATES-1:3];
  assign w_next_ring = {r_tstate[T_STATES-2:0], r_tstate[T_STATES-1]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mode   <= MODE_RUN;
      r_pc     <= LP_RESET_ADDR;
      r_mar    <= LP_RESET_ADDR;
      r_tstate <= LP_T1;
      r_wrap   <= 1'b0;
    end else if (r_mode == MODE_HALTED) begin
      r_tstate <= '0;
      r_wrap   <= 1'b0;
    end else if (!w_legal) begin
      r_tstate <= LP_T1;
      r_wrap   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (r_tstate[0]) begin
        r_mar <= r_pc;
      end
      if (r_tstate[1]) begin
        r_pc   <= r_pc + 1'b1;
        r_wrap <= (r_pc == LP_ALL_ONES);
      end
      // Halt wins over jump/end in the same execute cycle and freezes the PC.
      if (w_in_exec && i_halt) begin
        r_mode   <= MODE_HALTED;
        r_tstate <= '0;
      end else begin
        if (w_in_exec && i_jump) begin
          r_pc <= i_jump_addr;
        end
        if (w_in_exec && i_end) begin
          r_tstate <= LP_T1;
        end else begin
          r_tstate <= w_next_ring;
        end
      end
    end
  end

  assign o_address = r_mar;
  assign o_pc      = r_pc;
  assign o_tstate  = r_tstate;
  assign o_ir_load = r_tstate[2];
  assign o_wrap    = r_wrap;
  assign o_halted  = (r_mode == MODE_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two parameterisations share one stimulus stream and
// are compared every cycle against an integer-level model of the fetch rules.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst;
  logic       jump;
  logic [7:0] jaddr;
  logic       endIn;
  logic       halt;

  logic [3:0] address0, pc0;
  logic [5:0] tstate0;
  logic       irLoad0, wrap0, halted0;
  logic [7:0] address1, pc1;
  logic [5:0] tstate1;
  logic       irLoad1, wrap1, halted1;

  fetch_sequencer #(.ADDR_WIDTH(4), .T_STATES(6), .RESET_ADDR(0)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_jump(jump), .i_jump_addr(jaddr[3:0]),
    .i_end(endIn), .i_halt(halt), .o_address(address0), .o_pc(pc0),
    .o_tstate(tstate0), .o_ir_load(irLoad0), .o_wrap(wrap0), .o_halted(halted0)
  );

  fetch_sequencer #(.ADDR_WIDTH(8), .T_STATES(6), .RESET_ADDR(128)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_jump(jump), .i_jump_addr(jaddr),
    .i_end(endIn), .i_halt(halt), .o_address(address1), .o_pc(pc1),
    .o_tstate(tstate1), .o_ir_load(irLoad1), .o_wrap(wrap1), .o_halted(halted1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Model: T-state as an integer 1..N (0 = halted), PC/MAR as plain integers.
  localparam int N = 6;
  int mAw[2]   = '{4, 8};
  int mRst[2]  = '{0, 128};
  int mT[2];
  int mPc[2];
  int mMar[2];
  int mWrap[2];
  bit mValid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelStep(input bit r, input bit j, input int ja, input bit e, input bit h);
    for (int k = 0; k < 2; k++) begin
      int maxv;
      maxv = (1 << mAw[k]) - 1;
      if (r) begin
        mT[k] = 1; mPc[k] = mRst[k]; mMar[k] = mRst[k]; mWrap[k] = 0;
      end else if (mT[k] == 0) begin
        mWrap[k] = 0;
      end else begin
        mWrap[k] = 0;
        if (mT[k] == 1) begin
          mMar[k] = mPc[k]; mT[k] = 2;
        end else if (mT[k] == 2) begin
          mWrap[k] = (mPc[k] == maxv) ? 1 : 0;
          mPc[k] = (mPc[k] + 1) % (maxv + 1);
          mT[k] = 3;
        end else if (mT[k] == 3) begin
          mT[k] = 4;
        end else if (h) begin
          mT[k] = 0;
        end else begin
          if (j) mPc[k] = ja & maxv;
          mT[k] = (e || mT[k] == N) ? 1 : mT[k] + 1;
        end
      end
    end
    if (r) mValid = 1'b1;
  endtask

  task automatic compareAll();
    int expT;
    for (int k = 0; k < 2; k++) begin
      expT = (mT[k] == 0) ? 0 : (1 << (mT[k] - 1));
      if (k == 0) begin
        checkOutput("dut0.tstate",  32'(tstate0),  32'(expT));
        checkOutput("dut0.pc",      32'(pc0),      32'(mPc[0]));
        checkOutput("dut0.address", 32'(address0), 32'(mMar[0]));
        checkOutput("dut0.ir_load", 32'(irLoad0),  32'(mT[0] == 3));
        checkOutput("dut0.wrap",    32'(wrap0),    32'(mWrap[0]));
        checkOutput("dut0.halted",  32'(halted0),  32'(mT[0] == 0));
      end else begin
        checkOutput("dut1.tstate",  32'(tstate1),  32'(expT));
        checkOutput("dut1.pc",      32'(pc1),      32'(mPc[1]));
        checkOutput("dut1.address", 32'(address1), 32'(mMar[1]));
        checkOutput("dut1.ir_load", 32'(irLoad1),  32'(mT[1] == 3));
        checkOutput("dut1.wrap",    32'(wrap1),    32'(mWrap[1]));
        checkOutput("dut1.halted",  32'(halted1),  32'(mT[1] == 0));
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare at negedge.
  task automatic applyStimulus(input bit r, input bit j, input int ja, input bit e, input bit h);
    rst = r; jump = j; jaddr = 8'(ja); endIn = e; halt = h;
    @(posedge clk);
    modelStep(r, j, ja, e, h);
    @(negedge clk);
    if (mValid) compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; jump = 1'b0; jaddr = '0; endIn = 1'b0; halt = 1'b0;
    @(negedge clk);

    // Plain ring after reset
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lit.reset.tstate", 32'(tstate0), 32'h01);
    checkOutput("lit.reset.pc", 32'(pc0), 32'h0);
    checkOutput("lit.reset.pc1", 32'(pc1), 32'h80);
    for (int s = 1; s <= 12; s++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (s == 2) begin
        checkOutput("lit.t1.pc_t3", 32'(pc0), 32'h1);
        checkOutput("lit.t1.irload", 32'(irLoad0), 32'h1);
      end
      if (s == 7) checkOutput("lit.t1.addr_2nd_t2", 32'(address0), 32'h1);
      if (s == 8) checkOutput("lit.t1.pc_2nd_t3", 32'(pc0), 32'h2);
      if (s == 12) checkOutput("lit.t1.back_t1", 32'(tstate0), 32'h01);
    end

    // PC wrap after 16 instructions
    applyStimulus(1, 0, 0, 0, 0);
    for (int s = 1; s <= 97; s++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (s == 91) checkOutput("lit.wrap.pc15", 32'(pc0), 32'hF);
      if (s == 92) begin
        checkOutput("lit.wrap.pc0", 32'(pc0), 32'h0);
        checkOutput("lit.wrap.pulse", 32'(wrap0), 32'h1);
      end
      if (s == 93) checkOutput("lit.wrap.cleared", 32'(wrap0), 32'h0);
      if (s == 96) checkOutput("lit.wrap.addr15", 32'(address0), 32'hF);
      if (s == 97) checkOutput("lit.wrap.addr0", 32'(address0), 32'h0);
    end

    // Jump in T4, ignored jump in T2, jump+end in T4
    applyStimulus(1, 0, 0, 0, 0);
    idle(3);
    applyStimulus(0, 1, 'hA, 0, 0);
    checkOutput("lit.jump.pc", 32'(pc0), 32'hA);
    checkOutput("lit.jump.t5", 32'(tstate0), 32'h10);
    idle(3);
    checkOutput("lit.jump.addr", 32'(address0), 32'hA);
    applyStimulus(0, 1, 5, 0, 0);
    checkOutput("lit.jump.t2_ignored", 32'(pc0), 32'hB);
    idle(1);
    applyStimulus(0, 1, 3, 1, 0);
    checkOutput("lit.end.t1", 32'(tstate0), 32'h01);
    checkOutput("lit.end.pc", 32'(pc0), 32'h3);

    // Halt beats jump; only reset exits
    idle(4);
    applyStimulus(0, 1, 9, 0, 1);
    checkOutput("lit.halt.flag", 32'(halted0), 32'h1);
    checkOutput("lit.halt.tstate", 32'(tstate0), 32'h0);
    checkOutput("lit.halt.pc", 32'(pc0), 32'h4);
    for (int i = 0; i < 20; i++)
      applyStimulus(0, 1'($urandom), int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    checkOutput("lit.halt.pc_frozen", 32'(pc0), 32'h4);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lit.halt.exit", 32'(halted0), 32'h0);

    // Reset during T2 with PC=7 suppresses the increment
    idle(3);
    applyStimulus(0, 1, 7, 0, 0);
    idle(3);
    checkOutput("lit.rst.pc7", 32'(pc0), 32'h7);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("lit.rst.pc0", 32'(pc0), 32'h0);
    checkOutput("lit.rst.pc1", 32'(pc1), 32'h80);
    checkOutput("lit.rst.t1", 32'(tstate0), 32'h01);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 99) < 2,
                    $urandom_range(0, 3) == 0,
                    int'($urandom_range(0, 255)),
                    $urandom_range(0, 4) == 0,
                    $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
